// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit op encodings, FSM states and decode helpers
//
// Shared by load_store_unit and lsu_align. No ports.

package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  function automatic logic is_store(lsu_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Words need addr[1:0]==0, halfwords need addr[0]==0, bytes are always aligned.
  function automatic logic is_misaligned(lsu_op_e op, logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and DataMemory bus of the load/store unit
//
// Signals:
//   req_*        request handshake from the MEM stage (valid/ready, op, addr, data)
//   resp_*       completion handshake back to the MEM stage (valid/ready, data, err)
//   mem_*        DataMemory port (word address, write data, write/read strobes, read data)
// Modports: slave = load/store unit view, master = pipeline + memory view.

interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_address, mem_write_data, mem_write, mem_read
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - sub-word load extraction/extension and store merge (combinational)
//
// Ports:
//   op         latched access type
//   byte_sel   addr[1:0] of the access
//   word       word read from DataMemory
//   data       store data from the request
//   load_data  extracted and sign/zero-extended load result
//   store_word word to write back: data for SW, read word with the addressed lane replaced for SH/SB

module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] word,
  input  logic [31:0] data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{byte_sel, 3'b000} +: 8];
    half_v = byte_sel[1] ? word[31:16] : word[15:0];

    case (op)
      OP_LW:   load_data = word;
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'h0000, half_v};
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'h000000, byte_v};
      default: load_data = 32'h0;
    endcase

    store_word = word;
    case (op)
      OP_SW: store_word = data;
      OP_SH: begin
        if (byte_sel[1]) store_word[31:16] = data[15:0];
        else             store_word[15:0]  = data[15:0];
      end
      OP_SB:   store_word[{byte_sel, 3'b000} +: 8] = data[7:0];
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for word-organised DataMemory
//
// Ports:
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    load_store_unit_if.slave: request, response and DataMemory signals
// One request at a time. Sub-word stores do read-modify-write (READ then WRITE).

module load_store_unit
  import lsu_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_e  state, state_nxt;
  lsu_op_e     op_q;
  logic [31:0] addr_q, data_q, word_q, resp_data_q;
  logic        resp_err_q;
  logic [31:0] load_data, merged;
  lsu_op_e     req_op;

  assign req_op = lsu_op_e'(bus.req_op);

  lsu_align u_align (
    .op         (op_q),
    .byte_sel   (addr_q[1:0]),
    .word       (bus.mem_read_data),
    .data       (data_q),
    .load_data  (load_data),
    .store_word (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (is_misaligned(req_op, bus.req_addr[1:0])) state_nxt = ST_RESP;
          else if (req_op == OP_SW)                     state_nxt = ST_WRITE;
          else                                          state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = is_store(op_q) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  if (bus.resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and response registers; the response is zeroed on handshake
  // so resp_data/resp_err read 0 whenever no response is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_LW;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      word_q      <= 32'h0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= req_op;
            addr_q      <= bus.req_addr;
            data_q      <= bus.req_data;
            resp_data_q <= 32'h0;
            resp_err_q  <= is_misaligned(req_op, bus.req_addr[1:0]);
          end
        end
        ST_READ: begin
          if (is_store(op_q)) word_q      <= merged;
          else                resp_data_q <= load_data;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes decode straight from state so reset drops them immediately.
  always_comb begin
    bus.req_ready      = (state == ST_IDLE);
    bus.resp_valid     = (state == ST_RESP);
    bus.resp_data      = resp_data_q;
    bus.resp_err       = resp_err_q;
    bus.mem_read       = (state == ST_READ);
    bus.mem_write      = (state == ST_WRITE);
    bus.mem_address    = 32'h0;
    bus.mem_write_data = 32'h0;
    if (state == ST_READ || state == ST_WRITE)
      bus.mem_address = {2'b00, addr_q[31:2]};
    if (state == ST_WRITE)
      bus.mem_write_data = (op_q == OP_SW) ? data_q : word_q;
  end

endmodule
